// File: rtl/seven_seg_scan_ctrl_pkg.sv
// rtl/seven_seg_scan_ctrl_pkg.sv - shared constants and helpers for the 7-seg scan controller
package seven_seg_scan_ctrl_pkg;

    localparam logic [3:0] SEG_CODE_BLANK = 4'hF;
    localparam logic [3:0] BCD_MAX        = 4'd9;

    typedef struct packed {
        logic [3:0] code;
        logic       dp_n;
    } seg_out_t;

    function automatic int idx_width(input int n_digits);
        return (n_digits > 1) ? $clog2(n_digits) : 1;
    endfunction

    function automatic logic bcd_invalid(input logic [3:0] nibble);
        return nibble > BCD_MAX;
    endfunction

    // A blanked digit keeps its decimal point; only the segment code is forced dark.
    function automatic seg_out_t digit_out(input logic [3:0] nibble, input logic suppress,
                                           input logic dp);
        seg_out_t o;
        o.code = (bcd_invalid(nibble) || suppress) ? SEG_CODE_BLANK : nibble;
        o.dp_n = ~dp;
        return o;
    endfunction

endpackage

// File: rtl/seven_seg_scan_ctrl_if.sv
// rtl/seven_seg_scan_ctrl_if.sv - display value in / multiplexed segment drive out
interface seven_seg_scan_ctrl_if #(
    parameter int N_DIGITS = 4
);
    logic                  enable_i;
    logic                  lz_en_i;
    logic                  load_i;
    logic [4*N_DIGITS-1:0] digits_bcd_i;
    logic [N_DIGITS-1:0]   dp_in_i;
    logic [3:0]            dec_code_o;
    logic                  dp_n_o;
    logic [N_DIGITS-1:0]   an_n_o;
    logic                  frame_tick_o;
    logic                  bcd_err_o;

    modport master (
        output enable_i, lz_en_i, load_i, digits_bcd_i, dp_in_i,
        input  dec_code_o, dp_n_o, an_n_o, frame_tick_o, bcd_err_o
    );

    modport slave (
        input  enable_i, lz_en_i, load_i, digits_bcd_i, dp_in_i,
        output dec_code_o, dp_n_o, an_n_o, frame_tick_o, bcd_err_o
    );
endinterface

// File: rtl/seven_seg_scan_ctrl_scan_tick_gen.sv
// rtl/seven_seg_scan_ctrl_scan_tick_gen.sv - digit-slot prescaler and digit index counter
module scan_tick_gen
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2,
    localparam int PW = $clog2(REFRESH_DIV),
    localparam int IW = idx_width(N_DIGITS)
) (
    input  logic          clk,
    input  logic          rst_n,
    output logic          slot_wrap_o,
    output logic          frame_tick_o,
    output logic          in_guard_o,
    output logic [IW-1:0] idx_o
);

    logic [PW-1:0] prescaler_q, prescaler_d;
    logic [IW-1:0] idx_q, idx_d;

    assign slot_wrap_o  = (prescaler_q == PW'(REFRESH_DIV - 1));
    assign frame_tick_o = slot_wrap_o && (idx_q == IW'(N_DIGITS - 1));
    assign idx_o        = idx_q;

    generate
        if (BLANK_CYCLES == 0) begin : g_no_guard
            assign in_guard_o = 1'b0;
        end else begin : g_guard
            assign in_guard_o = (prescaler_q < PW'(BLANK_CYCLES));
        end
    endgenerate

    always_comb begin
        prescaler_d = prescaler_q + PW'(1);
        idx_d       = idx_q;
        if (slot_wrap_o) begin
            prescaler_d = '0;
            idx_d       = (idx_q == IW'(N_DIGITS - 1)) ? '0 : idx_q + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler_q <= '0;
            idx_q       <= '0;
        end else begin
            prescaler_q <= prescaler_d;
            idx_q       <= idx_d;
        end
    end

endmodule

// File: rtl/seven_seg_scan_ctrl.sv
// rtl/seven_seg_scan_ctrl.sv - multiplexed common-anode 7-seg driver with tear-free shadows
module seven_seg_scan_ctrl
    import seven_seg_scan_ctrl_pkg::*;
#(
    parameter int N_DIGITS     = 4,
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    seven_seg_scan_ctrl_if.slave bus
);

    localparam int IW = idx_width(N_DIGITS);
    localparam logic [N_DIGITS-1:0] AN_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

    logic          slot_wrap;
    logic          frame_tick;
    logic          in_guard;
    logic [IW-1:0] idx;

    scan_tick_gen #(
        .N_DIGITS    (N_DIGITS),
        .REFRESH_DIV (REFRESH_DIV),
        .BLANK_CYCLES(BLANK_CYCLES)
    ) u_tick (
        .clk         (clk),
        .rst_n       (rst_n),
        .slot_wrap_o (slot_wrap),
        .frame_tick_o(frame_tick),
        .in_guard_o  (in_guard),
        .idx_o       (idx)
    );

    logic [N_DIGITS-1:0][3:0] pending_q, active_q, load_digits;
    logic [N_DIGITS-1:0]      pending_dp_q, active_dp_q;
    logic                     bcd_err_q;
    logic [N_DIGITS-1:0]      an_n_q, an_n_d;
    logic [3:0]               dec_code_q, dec_code_d;
    logic                     dp_n_q, dp_n_d;
    logic                     frame_tick_q;

    logic                     frame_edge;
    logic                     load_bad;
    logic                     seen_nonzero;
    logic [N_DIGITS-1:0]      suppress;
    seg_out_t                 cur;

    assign load_digits = bus.digits_bcd_i;
    assign frame_edge  = slot_wrap && frame_tick;

    always_comb begin
        load_bad = 1'b0;
        for (int d = 0; d < N_DIGITS; d++) begin
            load_bad = load_bad | bcd_invalid(load_digits[d]);
        end
    end

    // Walk down from the top digit; everything above the first nonzero one is a leading zero.
    always_comb begin
        seen_nonzero = 1'b0;
        suppress     = '0;
        for (int d = N_DIGITS - 1; d >= 0; d--) begin
            seen_nonzero = seen_nonzero | (active_q[d] != 4'd0);
            suppress[d]  = bus.lz_en_i && !seen_nonzero && (d != 0);
        end
    end

    always_comb begin
        cur        = digit_out(active_q[idx], suppress[idx], active_dp_q[idx]);
        an_n_d     = '1;
        dec_code_d = SEG_CODE_BLANK;
        dp_n_d     = 1'b1;
        if (!in_guard && bus.enable_i) begin
            an_n_d     = ~(AN_ONE << idx);
            dec_code_d = cur.code;
            dp_n_d     = cur.dp_n;
        end
    end

    // A load landing on the frame boundary bypasses pending so it is not lost for a frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q    <= '0;
            pending_dp_q <= '0;
            active_q     <= '0;
            active_dp_q  <= '0;
            bcd_err_q    <= 1'b0;
        end else begin
            if (bus.load_i) begin
                pending_q    <= load_digits;
                pending_dp_q <= bus.dp_in_i;
            end
            if (frame_edge) begin
                active_q    <= bus.load_i ? load_digits : pending_q;
                active_dp_q <= bus.load_i ? bus.dp_in_i : pending_dp_q;
            end
            if (bus.load_i && load_bad) begin
                bcd_err_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            an_n_q       <= '1;
            dec_code_q   <= SEG_CODE_BLANK;
            dp_n_q       <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            an_n_q       <= an_n_d;
            dec_code_q   <= dec_code_d;
            dp_n_q       <= dp_n_d;
            frame_tick_q <= frame_tick;
        end
    end

    assign bus.an_n_o       = an_n_q;
    assign bus.dec_code_o   = dec_code_q;
    assign bus.dp_n_o       = dp_n_q;
    assign bus.frame_tick_o = frame_tick_q;
    assign bus.bcd_err_o    = bcd_err_q;

endmodule
